// File: rtl/env_vca_pkg.sv
// Shared definitions for the VCA stage and the envelope generator feeding it.
package env_vca_pkg;

  localparam int ENV_DATA_WIDTH     = 16;
  localparam int ENV_SAMPLE_WIDTH   = 16;
  localparam int ENV_SLEW_SHIFT     = 4;
  localparam int ENV_SLEW_SHIFT_MAX = 8;

  // Smoother shifts beyond the max make the slew so slow it is useless.
  function automatic bit slew_shift_legal(input int shift);
    return (shift >= 0) && (shift <= ENV_SLEW_SHIFT_MAX);
  endfunction

  // Half an LSB of the fixed-point gain, added before truncation.
  function automatic logic [63:0] round_half_const(input int frac_bits);
    return 64'd1 << (frac_bits - 1);
  endfunction

endpackage

// File: rtl/env_vca_slew.sv
// Envelope slew limiter: moves a fraction of the remaining distance to the
// target on each update, with a minimum step of one LSB so it always lands.
module env_slew
  import env_vca_pkg::*;
#(
  parameter int DATA_WIDTH = ENV_DATA_WIDTH,
  parameter int SLEW_SHIFT = ENV_SLEW_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_i,
  input  logic [DATA_WIDTH-1:0] target_i,
  output logic [DATA_WIDTH-1:0] smooth_o,
  output logic [DATA_WIDTH-1:0] smooth_next_o
);

  logic [DATA_WIDTH-1:0] smooth_q;
  logic [DATA_WIDTH-1:0] smooth_d;
  logic signed [DATA_WIDTH:0] diff;
  logic signed [DATA_WIDTH:0] step_raw;
  logic signed [DATA_WIDTH:0] step;
  logic signed [DATA_WIDTH:0] sum;
  logic unused_sum_msb;

  // Next smoothed value; |step| <= |diff| keeps the sum inside the unsigned range.
  always_comb begin
    diff     = $signed({1'b0, target_i}) - $signed({1'b0, smooth_q});
    step_raw = diff >>> SLEW_SHIFT;
    step     = step_raw;
    if ((step_raw == '0) && (diff != '0)) begin
      step = diff[DATA_WIDTH] ? '1 : {{DATA_WIDTH{1'b0}}, 1'b1};
    end
    sum      = $signed({1'b0, smooth_q}) + step;
    smooth_d = sum[DATA_WIDTH-1:0];
  end

  assign unused_sum_msb = sum[DATA_WIDTH];

  // Smoothed gain only moves when a sample is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smooth_q <= '0;
    end else if (upd_i) begin
      smooth_q <= smooth_d;
    end
  end

  assign smooth_o      = smooth_q;
  assign smooth_next_o = smooth_d;

endmodule

// File: rtl/env_vca.sv
// Voltage-controlled amplifier: scales signed samples by the slewed envelope
// through a two-stage valid/ready pipeline (register, then multiply+round).
module env_vca
  import env_vca_pkg::*;
#(
  parameter int DATA_WIDTH   = ENV_DATA_WIDTH,
  parameter int SAMPLE_WIDTH = ENV_SAMPLE_WIDTH,
  parameter int SLEW_SHIFT   = ENV_SLEW_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   env_level,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_sample,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [SAMPLE_WIDTH-1:0] m_sample,
  output logic [DATA_WIDTH-1:0]   env_smooth,
  output logic                    idle
);

  localparam int PROD_W = SAMPLE_WIDTH + DATA_WIDTH + 1;
  localparam logic [PROD_W-1:0] ROUND_K = PROD_W'(round_half_const(DATA_WIDTH));

  if (!slew_shift_legal(SLEW_SHIFT)) begin : g_bad_shift
    $error("env_vca: SLEW_SHIFT must be within 0..8");
  end

  logic                    en;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   gain_next;

  logic                    s1_valid_q;
  logic [SAMPLE_WIDTH-1:0] s1_sample_q;
  logic [DATA_WIDTH-1:0]   s1_gain_q;

  logic                    m_valid_q;
  logic [SAMPLE_WIDTH-1:0] m_sample_q;
  logic [SAMPLE_WIDTH-1:0] m_sample_d;

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] rounded;
  logic                     unused_round_bits;

  // Whole pipeline advances together; s_ready is combinational from m_ready.
  assign en      = !m_valid_q || m_ready;
  assign accept  = s_valid && en;
  assign s_ready = en;

  env_slew #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLEW_SHIFT (SLEW_SHIFT)
  ) u_slew (
    .clk           (clk),
    .rst_n         (rst_n),
    .upd_i         (accept),
    .target_i      (env_level),
    .smooth_o      (env_smooth),
    .smooth_next_o (gain_next)
  );

  // Stage 1: capture the sample with the gain as updated by this accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_gain_q   <= '0;
    end else if (en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sample_q <= s_sample;
        s1_gain_q   <= gain_next;
      end
    end
  end

  // Signed sample times zero-extended gain, rounded half up, then drop the
  // fractional gain bits. The result always fits the sample width.
  always_comb begin
    sample_ext = {{(DATA_WIDTH + 1){s1_sample_q[SAMPLE_WIDTH-1]}}, s1_sample_q};
    gain_ext   = {{(SAMPLE_WIDTH + 1){1'b0}}, s1_gain_q};
    product    = sample_ext * gain_ext;
    rounded    = product + $signed(ROUND_K);
    m_sample_d = rounded[DATA_WIDTH +: SAMPLE_WIDTH];
  end

  assign unused_round_bits = ^{rounded[DATA_WIDTH-1:0], rounded[PROD_W-1]};

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_sample_q <= '0;
    end else if (en) begin
      m_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        m_sample_q <= m_sample_d;
      end
    end
  end

  assign m_valid  = m_valid_q;
  assign m_sample = m_sample_q;
  assign idle     = !s1_valid_q && !m_valid_q;

endmodule

// File: tb/tb_env_vca.sv
// Bench for env_vca: two instances (no smoothing and default smoothing) share
// all stimulus; a high-level model predicts gains and scaled samples.
module tb_env_vca;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] env_level;
  logic        s_valid;
  logic [15:0] s_sample;
  logic        m_ready;

  logic        s_ready0, m_valid0, idle0;
  logic [15:0] m_sample0, env_smooth0;
  logic        s_ready4, m_valid4, idle4;
  logic [15:0] m_sample4, env_smooth4;

  int n_cmp = 0;
  int n_bad = 0;
  int sm0 = 0;
  int sm4 = 0;
  int q0[$];
  int q4[$];

  always #5 clk = ~clk;

  env_vca #(.DATA_WIDTH(16), .SAMPLE_WIDTH(16), .SLEW_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .env_level(env_level), .s_valid(s_valid),
    .s_ready(s_ready0), .s_sample(s_sample), .m_valid(m_valid0), .m_ready(m_ready),
    .m_sample(m_sample0), .env_smooth(env_smooth0), .idle(idle0));

  env_vca #(.DATA_WIDTH(16), .SAMPLE_WIDTH(16), .SLEW_SHIFT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .env_level(env_level), .s_valid(s_valid),
    .s_ready(s_ready4), .s_sample(s_sample), .m_valid(m_valid4), .m_ready(m_ready),
    .m_sample(m_sample4), .env_smooth(env_smooth4), .idle(idle4));

  // Smoother rule: move by diff/2^shift, at least one LSB toward the target.
  function automatic int slew_model(input int cur, input int tgt, input int sh);
    int d;
    int st;
    d  = tgt - cur;
    st = d >>> sh;
    if (st == 0 && d != 0) st = (d > 0) ? 1 : -1;
    return cur + st;
  endfunction

  // Scaled output: round(sample * gain / 65536), ties rounded up.
  function automatic int vca_model(input logic [15:0] smp, input int gain);
    longint p;
    p = longint'($signed(smp)) * longint'(gain);
    return int'((p + 64'sd32768) >>> 16);
  endfunction

  // One clock of stimulus. Scores outputs taken this cycle against the model
  // queues and predicts what an accept this cycle will produce.
  task automatic drive_cycle(input logic sv, input logic [15:0] smp,
                             input logic [15:0] lvl, input logic mr,
                             output logic acc);
    logic take;
    int   e0;
    int   e4;
    s_valid   = sv;
    s_sample  = smp;
    env_level = lvl;
    m_ready   = mr;
    #1;
    n_cmp++;
    if (s_ready0 !== (!m_valid0 || mr) || s_ready4 !== s_ready0) begin
      n_bad++;
      $display("FAIL s_ready: got %b/%b want %b", s_ready0, s_ready4, !m_valid0 || mr);
    end
    acc  = sv && s_ready0;
    take = m_valid0 && mr;
    if (take) begin
      n_cmp++;
      if (q0.size() == 0 || q4.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got m_sample %0d with empty model queue", $signed(m_sample0));
      end else begin
        e0 = q0.pop_front();
        e4 = q4.pop_front();
        if (m_sample0 !== 16'(e0) || m_sample4 !== 16'(e4) || m_valid4 !== 1'b1) begin
          n_bad++;
          $display("FAIL m_sample: got %0d/%0d want %0d/%0d", $signed(m_sample0),
                   $signed(m_sample4), e0, e4);
        end
      end
    end
    if (acc) begin
      sm0 = slew_model(sm0, int'(lvl), 0);
      sm4 = slew_model(sm4, int'(lvl), 4);
      q0.push_back(vca_model(smp, sm0));
      q4.push_back(vca_model(smp, sm4));
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (env_smooth0 !== 16'(sm0) || env_smooth4 !== 16'(sm4)) begin
      n_bad++;
      $display("FAIL env_smooth: got %h/%h want %h/%h", env_smooth0, env_smooth4,
               16'(sm0), 16'(sm4));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_valid   = 1'b0;
    m_ready   = 1'b0;
    s_sample  = '0;
    env_level = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    q4.delete();
    sm0 = 0;
    sm4 = 0;
  endtask

  task automatic test_drain();
    logic acc;
    repeat (4) drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
    n_cmp++;
    if (q0.size() != 0 || m_valid0 !== 1'b0 || idle0 !== 1'b1 || idle4 !== 1'b1) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, m_valid %b idle %b, want 0 pending, 0, 1",
               q0.size(), m_valid0, idle0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (m_valid0 !== 1'b0 || m_valid4 !== 1'b0 || m_sample0 !== 16'h0 ||
        m_sample4 !== 16'h0 || env_smooth0 !== 16'h0 || env_smooth4 !== 16'h0 ||
        idle0 !== 1'b1 || idle4 !== 1'b1 || s_ready0 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: got mv=%b ms=%h es=%h idle=%b rdy=%b want 0 0 0 1 1",
               m_valid0, m_sample0, env_smooth0, idle0, s_ready0);
    end
  endtask

  task automatic test_basic_scaling();
    logic acc;
    drive_cycle(1'b1, 16'd1000, 16'h8000, 1'b1, acc);
    n_cmp++;
    if (m_valid0 !== 1'b0 || idle0 !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_latency1: got m_valid %b idle %b want 0 0", m_valid0, idle0);
    end
    drive_cycle(1'b0, 16'd0, 16'h8000, 1'b1, acc);
    n_cmp++;
    if (m_valid0 !== 1'b1 || m_sample0 !== 16'd500) begin
      n_bad++;
      $display("FAIL basic_scaling: got valid %b sample %0d want 1 500", m_valid0,
               $signed(m_sample0));
    end
    test_drain();
  endtask

  task automatic test_extremes();
    logic acc;
    logic [15:0] lv[3]  = '{16'hFFFF, 16'hFFFF, 16'h0000};
    logic [15:0] sp[3]  = '{16'h8000, 16'h7FFF, 16'h7FFF};
    logic [15:0] ex[3]  = '{16'h8001, 16'h7FFF, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, sp[i], lv[i], 1'b1, acc);
      drive_cycle(1'b0, 16'h0, lv[i], 1'b0, acc);
      n_cmp++;
      if (m_valid0 !== 1'b1 || m_sample0 !== ex[i]) begin
        n_bad++;
        $display("FAIL extreme_%0d: got valid %b sample %h want 1 %h", i, m_valid0,
                 m_sample0, ex[i]);
      end
    end
    test_drain();
  endtask

  task automatic test_slew();
    logic acc;
    do_reset();
    drive_cycle(1'b1, 16'd100, 16'h1000, 1'b1, acc);
    n_cmp++;
    if (env_smooth4 !== 16'h0100) begin
      n_bad++;
      $display("FAIL slew_step1: got %h want 0100", env_smooth4);
    end
    drive_cycle(1'b1, 16'd100, 16'h1000, 1'b1, acc);
    n_cmp++;
    if (env_smooth4 !== 16'h01F0) begin
      n_bad++;
      $display("FAIL slew_step2: got %h want 01f0", env_smooth4);
    end
    do_reset();
    repeat (15) drive_cycle(1'b1, 16'd7, 16'h000F, 1'b1, acc);
    n_cmp++;
    if (env_smooth4 !== 16'h000F) begin
      n_bad++;
      $display("FAIL slew_min_step: got %h want 000f", env_smooth4);
    end
    drive_cycle(1'b1, 16'd7, 16'h0010, 1'b1, acc);
    n_cmp++;
    if (env_smooth4 !== 16'h0010) begin
      n_bad++;
      $display("FAIL slew_converge: got %h want 0010", env_smooth4);
    end
    test_drain();
  endtask

  task automatic test_backpressure();
    logic acc;
    logic [15:0] ms0, ms4, es4;
    repeat (4) drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, acc);
    ms0 = m_sample0;
    ms4 = m_sample4;
    es4 = env_smooth4;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, acc);
      n_cmp++;
      if (acc !== 1'b0 || s_ready0 !== 1'b0 || m_valid0 !== 1'b1 || m_sample0 !== ms0 ||
          m_sample4 !== ms4 || env_smooth4 !== es4) begin
        n_bad++;
        $display("FAIL stall_%0d: got rdy %b mv %b ms %h es %h want 0 1 %h %h", i,
                 s_ready0, m_valid0, m_sample0, env_smooth4, ms0, es4);
      end
    end
    repeat (6) drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, acc);
    test_drain();
  endtask

  task automatic test_bubbles();
    logic acc;
    logic hist[12];
    logic prev;
    for (int k = 0; k < 12; k++) begin
      drive_cycle((k % 2) == 0, 16'($urandom), 16'($urandom), 1'b1, acc);
      hist[k] = acc;
      prev = (k >= 1) ? hist[k-1] : 1'b0;
      n_cmp++;
      if (m_valid0 !== prev || idle0 !== !(hist[k] || prev)) begin
        n_bad++;
        $display("FAIL bubble_%0d: got m_valid %b idle %b want %b %b", k, m_valid0,
                 idle0, prev, !(hist[k] || prev));
      end
    end
    test_drain();
  endtask

  task automatic test_random();
    logic acc;
    logic [15:0] lvl;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 7))
        0:       lvl = 16'hFFFF;
        1:       lvl = 16'h0000;
        default: lvl = 16'($urandom);
      endcase
      drive_cycle($urandom_range(0, 9) < 7, 16'($urandom), lvl,
                  $urandom_range(0, 9) < 7, acc);
    end
    test_drain();
  endtask

  task automatic test_reset_midstream();
    logic acc;
    drive_cycle(1'b1, 16'd1234, 16'h4000, 1'b1, acc);
    drive_cycle(1'b1, 16'd2345, 16'h4000, 1'b1, acc);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_valid0 !== 1'b0 || m_valid4 !== 1'b0 || env_smooth0 !== 16'h0 ||
        env_smooth4 !== 16'h0 || idle0 !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: got mv %b es %h/%h idle %b want 0 0 0 1", m_valid0,
               env_smooth0, env_smooth4, idle0);
    end
    q0.delete();
    q4.delete();
    sm0 = 0;
    sm4 = 0;
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 16'd4000, 16'h1000, 1'b1, acc);
    n_cmp++;
    if (env_smooth4 !== 16'h0100 || env_smooth0 !== 16'h1000) begin
      n_bad++;
      $display("FAIL reset_restart: got %h/%h want 1000/0100", env_smooth0, env_smooth4);
    end
    drive_cycle(1'b0, 16'd0, 16'h1000, 1'b0, acc);
    n_cmp++;
    if (m_valid4 !== 1'b1 || m_sample4 !== 16'd16 || m_sample0 !== 16'd250) begin
      n_bad++;
      $display("FAIL reset_first_out: got %0d/%0d want 250/16", $signed(m_sample0),
               $signed(m_sample4));
    end
    test_drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    m_ready   = 1'b0;
    s_sample  = '0;
    env_level = '0;
    @(negedge clk);
    test_reset();
    test_basic_scaling();
    test_extremes();
    test_slew();
    test_backpressure();
    test_bubbles();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/env_vca.md
# env_vca

Voltage-controlled amplifier stage directly downstream of the ADSR envelope generator. It multiplies a stream of signed oscillator samples by the unsigned envelope level. A slew limiter on the envelope suppresses zipper noise. A two-stage valid/ready pipeline delivers scaled samples to the mixer/DAC path.

## Interface
Parameters:
- `DATA_WIDTH`, 16, envelope width (unsigned; all-ones ≈ unity gain).
- `SAMPLE_WIDTH`, 16, signed audio sample width.
- `SLEW_SHIFT`, 4, smoother shift, legal range 0..8; 0 disables smoothing.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `env_level`  in  DATA_WIDTH  envelope target from the envelope generator; sampled only on input handshakes.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  input ready.
- `s_sample`  in  SAMPLE_WIDTH  signed input sample.
- `m_valid`  out  1  output sample valid.
- `m_ready`  in  1  downstream ready.
- `m_sample`  out  SAMPLE_WIDTH  signed scaled sample.
- `env_smooth`  out  DATA_WIDTH  current smoothed gain, for debug/metering.
- `idle`  out  1  high when both pipeline stages are empty.

## Operation
- **Accept:** an input is accepted when `s_valid && s_ready`. Nothing advances without an accept, including `env_smooth`.
- **Smoother update on accept:**
  - diff = `env_level − env_smooth`, signed, DATA_WIDTH+1 bits.
  - step = diff >>> `SLEW_SHIFT` (arithmetic shift).
  - If step == 0 and diff != 0, step = sign(diff)·1. This guarantees exact convergence.
  - `env_smooth` <= `env_smooth` + step. The result never leaves [0, 2^DATA_WIDTH−1].
- **Gain used:** the accepted sample is scaled by the updated `env_smooth` value, not the old one.
- **Stage 1:** registers the sample and the updated gain, plus a valid bit.
- **Stage 2:** computes
  - product = sample × {1'b0, gain}, signed, SAMPLE_WIDTH+DATA_WIDTH+1 bits.
  - result = (product + 2^(DATA_WIDTH−1)) >>> DATA_WIDTH, i.e. round half up.
  - The result is registered into `m_sample`. It always fits SAMPLE_WIDTH, so no saturation logic is needed.
- **Gain of 0** gives `m_sample` = 0 exactly.
- **Ordering:** samples leave in order. None are dropped or duplicated.

## Timing
- **Reset values:** `env_smooth`=0, both valid bits 0, `m_valid`=0, `m_sample`=0, `idle`=1. Stage-1 data is don't-care.
- **Reset mid-stream:** in-flight samples are discarded. The first output after reset uses a smoother that restarts from 0.
- **Pipeline enable:** en = `!m_valid || m_ready`. `s_ready` = en, a combinational path from `m_ready`; this is accepted by design.
- **Stall:** when en=0, both stages hold. `m_sample` and `m_valid` stay stable until taken.
- **Latency:** 2 cycles from accept to `m_valid` with no backpressure. Throughput is 1 sample/cycle.
- **Bubbles:** a cycle with no accept inserts a bubble, which propagates through the valid bits.
- **`env_level` changes:** changes between accepts are ignored. Only the value present on the accept cycle counts.
- **Simultaneous output take and input accept** in the same cycle is a normal full-rate transfer.

## Structure
- **Shared synth package/header:** rounding-constant helper, `SLEW_SHIFT` legality check, DATA_WIDTH/SAMPLE_WIDTH defaults shared with the envelope generator.
- **Sub-module `env_slew`:** the smoother.
  - Inputs: `clk`, `rst_n`, update enable, target.
  - Outputs: the registered smoothed value and the combinational next value.
- **`env_vca` itself:** instantiates `env_slew` and contains the two-stage pipeline plus the multiplier.

## Test plan
- **Basic scaling:** `SLEW_SHIFT`=0, `env_level`=0x8000, `s_sample`=1000 → `m_sample`=500, `m_valid` 2 cycles after accept.
- **Full-scale extremes:** `SLEW_SHIFT`=0.
  - `env_level`=0xFFFF, sample −32768 → −32767.
  - Sample 32767 → 32767.
  - `env_level`=0 → 0.
- **Slew:**
  - `SLEW_SHIFT`=4, `env_smooth`=0, `env_level`=0x1000 → after accept 1 `env_smooth`=0x0100, after accept 2 0x01F0.
  - From 0x000F with target 0x0010 → 0x0010 in one accept.
- **Backpressure:**
  - Setup: continuous `s_valid`, `m_ready` held low 5 cycles.
  - Stall: `s_ready`=0, `m_sample` stable, `env_smooth` frozen.
  - Release: all samples emerge in order with no loss; the scoreboard matches the reference model.
- **Bubbles:** `s_valid` toggling every other cycle → `m_valid` pattern is delayed 2 cycles, `idle`=1 only when both stages are empty.
- **Reset mid-stream:** `rst_n` asserted with 2 samples in flight → `m_valid`=0, `env_smooth`=0 immediately (asynchronous). After release, the next accept restarts the slew from 0.
